// File: rtl/divider_seq_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the sequential restoring divider and its neighbours
//   in the modular-exponentiation datapath.
//   - div_state_e       : divider FSM state encoding (IDLE, ITER, FIX)
//   - DIV_WIDTH_DEFAULT : default operand width
//   - cond_negate()     : two's-complement negate-if, also used as |x| by
//                         passing the operand's sign bit as the negate flag
// -----------------------------------------------------------------------------
package divider_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 16;

   // Widest operand cond_negate() handles. Callers zero-extend into this
   // width and truncate the result back; the low bits of a two's-complement
   // negation do not depend on the upper (zero) bits, so this is exact.
   localparam int unsigned NEG_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   function automatic logic [NEG_MAX_W-1:0] cond_negate(
      input logic [NEG_MAX_W-1:0] value,
      input logic                 neg
   );
      return neg ? (~value + NEG_MAX_W'(1)) : value;
   endfunction

endpackage : divider_pkg

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
//   Sequential restoring divider, one quotient bit per clock, with per-operation
//   signed/unsigned mode, divide-by-zero and signed-overflow flags.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous reset, active low
//   start        in   operation request, sampled only in IDLE
//   signed_op    in   1 = two's-complement operands (sampled with start)
//   dividend     in   WIDTH, sampled with start
//   divisor      in   WIDTH, sampled with start
//   busy         out  operation in progress
//   done         out  one-cycle pulse, results valid from this cycle
//   quotient     out  WIDTH result, held until overwritten by the next FIX
//   remainder    out  WIDTH result, held until overwritten by the next FIX
//   div_by_zero  out  last operation had divisor == 0
//   overflow     out  last operation was signed MIN / -1
//   dbg_state    out  current FSM state (div_state_e encoding)
//
// Handshake: start is a request and "state == IDLE" is the implicit ready.
//   A request is accepted on a rising edge where the FSM is in IDLE and start
//   is high; busy rises on that edge. Requests while busy, or in the cycle
//   where the FIX edge is being taken, are dropped (no queueing). Completion
//   is signalled by done, a single-cycle pulse that never overlaps busy; the
//   earliest next request is accepted on the edge that ends the done cycle.
// -----------------------------------------------------------------------------
module divider_seq
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   // Partial remainder. It is always < divisor after a restore step, so its
   // top (WIDTH+1-th) bit is known zero between iterations and is only
   // materialised inside the shifted/trial values below.
   logic [WIDTH-1:0] rem_q;
   // Dividend magnitude; quotient bits shift in at the bottom as the dividend
   // bits shift out at the top, so this ends up holding |quotient|.
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] remo_q;
   logic             dz_q;
   logic             ov_q;

   // Operand preparation for an accepted start
   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic             is_zero;
   logic             is_ovf;

   // One restoring step
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             q_bit;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] dvd_d;

   always_comb begin
      dvd_neg = signed_op & dividend[WIDTH-1];
      dvs_neg = signed_op & divisor[WIDTH-1];
      dvd_mag = WIDTH'(cond_negate(NEG_MAX_W'(dividend), dvd_neg));
      dvs_mag = WIDTH'(cond_negate(NEG_MAX_W'(divisor), dvs_neg));
      is_zero = (divisor == '0);
      is_ovf  = signed_op && (dividend == MIN_VAL) && (divisor == '1);
   end

   always_comb begin
      r_shift = {rem_q, dvd_q[WIDTH-1]};
      trial   = r_shift - {1'b0, dvs_q};
      // The trial difference lies in [-divisor, divisor-1], so bit WIDTH is
      // its sign.
      q_bit   = ~trial[WIDTH];
      rem_d   = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
      dvd_d   = {dvd_q[WIDTH-2:0], q_bit};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quo_q     <= '0;
         remo_q    <= '0;
         dz_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  busy_q <= 1'b1;
                  dz_q   <= is_zero;
                  ov_q   <= is_ovf;
                  if (is_zero) begin
                     // Special results are preloaded so FIX can register
                     // them through the same path as a normal result.
                     dvd_q     <= '1;
                     rem_q     <= dividend;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                     state_q   <= FIX;
                  end else if (is_ovf) begin
                     dvd_q     <= MIN_VAL;
                     rem_q     <= '0;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                     state_q   <= FIX;
                  end else begin
                     dvd_q     <= dvd_mag;
                     dvs_q     <= dvs_mag;
                     rem_q     <= '0;
                     neg_quo_q <= dvd_neg ^ dvs_neg;
                     // Truncating division: remainder follows the dividend.
                     neg_rem_q <= dvd_neg;
                     cnt_q     <= CNT_W'(WIDTH);
                     state_q   <= ITER;
                  end
               end
            end

            ITER: begin
               rem_q <= rem_d;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= FIX;
               end
            end

            FIX: begin
               quo_q   <= WIDTH'(cond_negate(NEG_MAX_W'(dvd_q), neg_quo_q));
               remo_q  <= WIDTH'(cond_negate(NEG_MAX_W'(rem_q), neg_rem_q));
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = remo_q;
   assign div_by_zero = dz_q;
   assign overflow    = ov_q;
   assign dbg_state   = state_q;

endmodule : divider_seq

// File: tb/tb_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_seq
//   Directed bench for divider_seq at WIDTH=16. A reference model computes
//   results with plain integer division; literal expectations pin the model;
//   a scoreboard process compares every done pulse against the model.
// -----------------------------------------------------------------------------
module tb_divider_seq;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
   } res_t;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         signed_op = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         overflow;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   divider_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow),
      .dbg_state   (dbg_state)
   );

   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   res_t exp_q[$];

   // ---------------- check helpers ----------------
   task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %04h expected %04h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic res_t model(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t         res;
      logic [W-1:0] min_v;
      int           sa;
      int           sb;
      int           qi;
      int           ri;
      min_v        = '0;
      min_v[W-1]   = 1'b1;
      res          = '0;
      if (b == '0) begin
         res.q  = '1;
         res.r  = a;
         res.dz = 1'b1;
      end else if (sd && (a == min_v) && (b == '1)) begin
         res.q  = min_v;
         res.r  = '0;
         res.ov = 1'b1;
      end else if (!sd) begin
         res.q = a / b;
         res.r = a % b;
      end else begin
         sa    = int'($signed(a));
         sb    = int'($signed(b));
         qi    = sa / sb;
         ri    = sa % sb;
         res.q = qi[W-1:0];
         res.r = ri[W-1:0];
      end
      return res;
   endfunction

   function automatic res_t lit(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dz, input logic ov);
      res_t res;
      res.q  = q;
      res.r  = r;
      res.dz = dz;
      res.ov = ov;
      return res;
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      res_t e;
      if (rst) begin
         check_b("busy_done_exclusive", busy & done, 1'b0);
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
               e = exp_q.pop_front();
               check_w("sb_quotient", quotient, e.q);
               check_w("sb_remainder", remainder, e.r);
               check_b("sb_div_by_zero", div_by_zero, e.dz);
               check_b("sb_overflow", overflow, e.ov);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive_start(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start     = 1'b1;
      signed_op = sd;
      dividend  = a;
      divisor   = b;
      exp_q.push_back(model(sd, a, b));
      @(negedge clk);
      // Scramble operands so a design that fails to latch them shows up.
      start     = 1'b0;
      signed_op = 1'($urandom_range(0, 1));
      dividend  = W'($urandom_range(0, 65535));
      divisor   = W'($urandom_range(0, 65535));
   endtask

   task automatic run_op(input string tag, input logic sd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input res_t pin);
      res_t m;
      int   k;
      int   lat_exp;
      m = model(sd, a, b);
      check_w({tag, "_model_q"}, m.q, pin.q);
      check_w({tag, "_model_r"}, m.r, pin.r);
      check_b({tag, "_model_dz"}, m.dz, pin.dz);
      check_b({tag, "_model_ov"}, m.ov, pin.ov);
      lat_exp = (m.dz || m.ov) ? 1 : W + 1;
      drive_start(sd, a, b);
      check_b({tag, "_busy_after_start"}, busy, 1'b1);
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_i({tag, "_latency"}, k, lat_exp);
      @(negedge clk);
      check_b({tag, "_busy_after_done"}, busy, 1'b0);
      check_b({tag, "_done_one_cycle"}, done, 1'b0);
      check_w({tag, "_q_held"}, quotient, m.q);
      check_w({tag, "_r_held"}, remainder, m.r);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int d0;
      int busy_cycles;

      repeat (3) @(negedge clk);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
      check_w("rst_quotient", quotient, '0);
      check_w("rst_remainder", remainder, '0);
      check_b("rst_div_by_zero", div_by_zero, 1'b0);
      check_b("rst_overflow", overflow, 1'b0);
      check_i("rst_state_idle", int'(dbg_state), 0);
      rst = 1'b1;
      @(negedge clk);

      run_op("u_11_3",      1'b0, 16'd11,   16'd3,    lit(16'h0003, 16'h0002, 1'b0, 1'b0));
      run_op("u_ffff_1",    1'b0, 16'hFFFF, 16'h0001, lit(16'hFFFF, 16'h0000, 1'b0, 1'b0));
      run_op("u_1234_ffff", 1'b0, 16'h1234, 16'hFFFF, lit(16'h0000, 16'h1234, 1'b0, 1'b0));
      run_op("s_m7_2",      1'b1, 16'hFFF9, 16'h0002, lit(16'hFFFD, 16'hFFFF, 1'b0, 1'b0));
      run_op("s_7_m2",      1'b1, 16'h0007, 16'hFFFE, lit(16'hFFFD, 16'h0001, 1'b0, 1'b0));
      run_op("u_100_0",     1'b0, 16'd100,  16'd0,    lit(16'hFFFF, 16'h0064, 1'b1, 1'b0));
      run_op("u_50_7",      1'b0, 16'd50,   16'd7,    lit(16'h0007, 16'h0001, 1'b0, 1'b0));
      run_op("s_min_m1",    1'b1, 16'h8000, 16'hFFFF, lit(16'h8000, 16'h0000, 1'b0, 1'b1));
      run_op("u_8000_ffff", 1'b0, 16'h8000, 16'hFFFF, lit(16'h0000, 16'h8000, 1'b0, 1'b0));
      run_op("s_m100_m7",   1'b1, 16'hFF9C, 16'hFFF9, lit(16'h000E, 16'hFFFE, 1'b0, 1'b0));
      run_op("s_m100_0",    1'b1, 16'hFF9C, 16'h0000, lit(16'hFFFF, 16'hFF9C, 1'b1, 1'b0));
      run_op("u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, lit(16'h0001, 16'h0000, 1'b0, 1'b0));
      run_op("s_min_1",     1'b1, 16'h8000, 16'h0001, lit(16'h8000, 16'h0000, 1'b0, 1'b0));
      run_op("s_min_2",     1'b1, 16'h8000, 16'h0002, lit(16'hC000, 16'h0000, 1'b0, 1'b0));

      // Reset asserted after edge 8 of an operation: abandoned, no done.
      drive_start(1'b0, 16'h4000, 16'd3);
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      check_b("midrst_busy", busy, 1'b0);
      check_b("midrst_done", done, 1'b0);
      check_w("midrst_quotient", quotient, '0);
      check_w("midrst_remainder", remainder, '0);
      check_b("midrst_div_by_zero", div_by_zero, 1'b0);
      check_b("midrst_overflow", overflow, 1'b0);
      check_i("midrst_state_idle", int'(dbg_state), 0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check_i("midrst_no_done", done_cnt - d0, 0);
      run_op("after_rst", 1'b0, 16'd1000, 16'd7, lit(16'd142, 16'd6, 1'b0, 1'b0));

      // start pulses while busy are ignored.
      d0 = done_cnt;
      drive_start(1'b0, 16'd60000, 16'd123);
      k = 0;
      busy_cycles = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
         if (busy) busy_cycles++;
         if (k == 3 || k == 10) begin
            start    = 1'b1;
            dividend = 16'd5;
            divisor  = 16'd1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_i("ignore_latency", k, W + 1);
      check_i("ignore_busy_cycles", busy_cycles, W);
      check_w("ignore_model_q", model(1'b0, 16'd60000, 16'd123).q, 16'd487);
      check_w("ignore_model_r", model(1'b0, 16'd60000, 16'd123).r, 16'd99);
      repeat (25) @(negedge clk);
      check_i("ignore_single_done", done_cnt - d0, 1);
      check_i("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_divider_seq
